// File: rtl/lpm_fifo_wr_arb_if.sv
// Producer and FIFO-write-side signals of the lpm_fifo write arbiter.
// master: producers + FIFO flag (the environment); slave: the arbiter.
interface lpm_fifo_wr_arb_if #(
    parameter int unsigned LPM_WIDTH = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_IDW   = 2
);
    logic                         sclr;
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*LPM_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]           req_ack;
    logic                         fifo_full;
    logic [LPM_WIDTH-1:0]         fifo_data;
    logic                         fifo_wrreq;
    logic                         grant_vld;
    logic [REQ_IDW-1:0]           grant_id;

    modport master (
        output sclr, req, req_data, fifo_full,
        input  req_ack, fifo_data, fifo_wrreq, grant_vld, grant_id
    );

    modport slave (
        input  sclr, req, req_data, fifo_full,
        output req_ack, fifo_data, fifo_wrreq, grant_vld, grant_id
    );
endinterface

// File: rtl/lpm_fifo_wr_arb.sv
// Round-robin arbiter sharing one lpm_fifo write port among NUM_REQ producers,
// with zero-latency ack, full-flag stalling and a per-grant burst cap.
module lpm_fifo_wr_arb #(
    parameter int unsigned LPM_WIDTH = 8,
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned REQ_IDW   = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input logic              clock,
    input logic              i_aclr,
    lpm_fifo_wr_arb_if.slave bus
);
    localparam int unsigned        CntW      = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CntW-1:0]    BurstLast = CntW'(MAX_BURST - 1);
    localparam logic [REQ_IDW-1:0] IdLast    = REQ_IDW'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e             r_state;
    logic [REQ_IDW-1:0] r_grant_id;
    logic [REQ_IDW-1:0] r_rr_ptr;
    logic [CntW-1:0]    r_burst_cnt;

    logic               w_grant_vld;
    logic               w_owner_req;
    logic               w_wr;
    logic               w_burst_last;
    logic               w_release;
    logic [REQ_IDW-1:0] w_next_ptr;
    logic               w_sel_vld;
    logic [REQ_IDW-1:0] w_sel_id;
    logic               w_resel_vld;
    logic [REQ_IDW-1:0] w_resel_id;

    // First requester at or after ptr, wrapping at NUM_REQ; MSB flags a hit.
    function automatic logic [REQ_IDW:0] rr_pick(input logic [REQ_IDW-1:0] ptr,
                                                 input logic [NUM_REQ-1:0] req);
        logic [REQ_IDW:0] res;
        int unsigned      idx;
        res = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!res[REQ_IDW] && req[idx[REQ_IDW-1:0]]) res = {1'b1, idx[REQ_IDW-1:0]};
        end
        return res;
    endfunction

    assign w_grant_vld  = (r_state == StGrant);
    assign w_owner_req  = bus.req[r_grant_id];
    assign w_wr         = w_grant_vld & w_owner_req & ~bus.fifo_full & ~bus.sclr;
    assign w_burst_last = (r_burst_cnt == BurstLast);
    assign w_release    = (w_wr & w_burst_last) | ~w_owner_req;
    assign w_next_ptr   = (r_grant_id == IdLast) ? '0 : r_grant_id + 1'b1;

    assign {w_sel_vld, w_sel_id}     = rr_pick(r_rr_ptr, bus.req);
    // Reselection from the post-release pointer lets the next owner start with no bubble.
    assign {w_resel_vld, w_resel_id} = rr_pick(w_next_ptr, bus.req);

    always_comb begin
        bus.req_ack             = '0;
        bus.req_ack[r_grant_id] = w_wr;
        bus.fifo_data           = '0;
        if (w_grant_vld) begin
            bus.fifo_data = bus.req_data[32'(r_grant_id) * LPM_WIDTH +: LPM_WIDTH];
        end
    end

    assign bus.fifo_wrreq = w_wr;
    assign bus.grant_vld  = w_grant_vld;
    assign bus.grant_id   = r_grant_id;

    always_ff @(posedge clock or posedge i_aclr) begin
        if (i_aclr) begin
            r_state     <= StIdle;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else if (bus.sclr) begin
            r_state     <= StIdle;
            r_grant_id  <= '0;
            r_rr_ptr    <= '0;
            r_burst_cnt <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_sel_vld) begin
                        r_state     <= StGrant;
                        r_grant_id  <= w_sel_id;
                        r_burst_cnt <= '0;
                    end
                end
                StGrant: begin
                    if (w_release) begin
                        r_rr_ptr    <= w_next_ptr;
                        r_burst_cnt <= '0;
                        if (w_resel_vld) begin
                            r_grant_id <= w_resel_id;
                        end else begin
                            r_state <= StIdle;
                        end
                    end else if (w_wr) begin
                        r_burst_cnt <= r_burst_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_lpm_fifo_wr_arb.sv
// Bench for lpm_fifo_wr_arb: per-cycle comparison against a queue/arithmetic arbiter
// model, plus hand-computed ack timelines and FIFO contents per scenario.
module tb_lpm_fifo_wr_arb;
    localparam int W   = 8;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int MB  = 4;

    logic clock = 1'b0;
    logic i_aclr;

    lpm_fifo_wr_arb_if #(.LPM_WIDTH(W), .NUM_REQ(N), .REQ_IDW(IDW)) bus ();

    lpm_fifo_wr_arb #(
        .LPM_WIDTH(W),
        .NUM_REQ  (N),
        .REQ_IDW  (IDW),
        .MAX_BURST(MB)
    ) dut (
        .clock (clock),
        .i_aclr(i_aclr),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Producers: each holds a list of words and requests while any remain.
    logic [W-1:0] prod_words[N][16];
    int           prod_len[N];
    int           prod_idx[N];

    // FIFO the arbiter writes into; full is derived from its occupancy.
    logic [W-1:0] fifo_q[$];
    int           fifo_depth = 1000;
    bit           pop_req = 1'b0;

    int           log_q[$];

    // Model state: owner -1 means no grant.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_cnt   = 0;

    logic [N-1:0] s_mack    = '0;
    logic         s_dut_wr  = 1'b0;
    logic [W-1:0] s_dut_data = '0;
    int           s_owner   = -1;

    function automatic int pick(input int ptr, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic int owner_of(input logic [N-1:0] v);
        if (v == '0) return -1;
        if (!$onehot(v)) return -2;
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -2;
    endfunction

    always @(posedge clock or posedge i_aclr) begin
        bit wr;
        bit rel;
        if (i_aclr) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (bus.sclr) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(m_ptr, bus.req);
            m_cnt   = 0;
        end else begin
            wr  = bus.req[m_owner] && !bus.fifo_full;
            rel = !bus.req[m_owner];
            if (wr) begin
                m_cnt++;
                rel = (m_cnt == MB);
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = pick(m_ptr, bus.req);
                m_cnt   = 0;
            end
        end
    end

    always @(negedge clock) begin
        logic [N-1:0] e_ack;
        logic         e_wr;
        logic [W-1:0] e_data;
        e_wr  = (m_owner >= 0) && bus.req[m_owner] && !bus.fifo_full && !bus.sclr;
        e_ack = '0;
        if (e_wr) e_ack[m_owner] = 1'b1;
        e_data = (m_owner >= 0) ? bus.req_data[m_owner * W +: W] : '0;
        check("grant_vld", 32'(bus.grant_vld), 32'(m_owner >= 0));
        if (m_owner >= 0) check("grant_id", 32'(bus.grant_id), 32'(m_owner));
        check("req_ack", 32'(bus.req_ack), 32'(e_ack));
        check("fifo_wrreq", 32'(bus.fifo_wrreq), 32'(e_wr));
        check("fifo_data", 32'(bus.fifo_data), 32'(e_data));
        s_mack     = e_ack;
        s_dut_wr   = bus.fifo_wrreq;
        s_dut_data = bus.fifo_data;
        s_owner    = owner_of(bus.req_ack);
    end

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            bus.req[i]              = (prod_idx[i] < prod_len[i]);
            bus.req_data[i*W +: W]  = bus.req[i] ? prod_words[i][prod_idx[i]] : '0;
        end
        bus.fifo_full = (fifo_q.size() >= fifo_depth);
    endtask

    // Effects of the edge just passed: producer pops, FIFO push/pop, then new inputs.
    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (s_mack[i]) prod_idx[i]++;
        end
        if (s_dut_wr) fifo_q.push_back(s_dut_data);
        if (pop_req) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_req = 1'b0;
        end
        s_mack   = '0;
        s_dut_wr = 1'b0;
        drive_bus();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clock);
            log_q.push_back(s_owner);
            #1;
            apply_inputs();
        end
    endtask

    task automatic load_prod(input int p, input int cnt, input logic [W-1:0] base);
        prod_len[p] = cnt;
        prod_idx[p] = 0;
        for (int k = 0; k < cnt; k++) prod_words[p][k] = base + W'(k);
    endtask

    task automatic clear_env();
        for (int i = 0; i < N; i++) begin
            prod_len[i] = 0;
            prod_idx[i] = 0;
        end
        fifo_q.delete();
        fifo_depth = 1000;
        log_q.delete();
    endtask

    task automatic quiesce();
        clear_env();
        bus.sclr = 1'b1;
        drive_bus();
        @(posedge clock);
        #1;
        apply_inputs();
        bus.sclr = 1'b0;
        clear_env();
        drive_bus();
    endtask

    function automatic int count_owner(input int who, input int from, input int to);
        int c = 0;
        for (int k = from; k <= to; k++) begin
            if (k < log_q.size() && log_q[k] == who) c++;
        end
        return c;
    endfunction

    initial begin
        int run_len;
        int max_run;
        bus.sclr = 1'b0;
        bus.req = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        clear_env();
        i_aclr = 1'b1;
        drive_bus();
        @(posedge clock);
        #1;
        check("rst_grant_vld", 32'(bus.grant_vld), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        check("rst_req_ack", 32'(bus.req_ack), 0);
        check("rst_fifo_wrreq", 32'(bus.fifo_wrreq), 0);
        check("rst_fifo_data", 32'(bus.fifo_data), 0);
        @(posedge clock);
        #1;
        i_aclr = 1'b0;

        // Async reset mid-burst of producer 2; producer 1 must win afterwards.
        log_q.delete();
        load_prod(2, 6, 8'h20);
        drive_bus();
        run(3);
        load_prod(1, 2, 8'h10);
        drive_bus();
        #1 i_aclr = 1'b1;
        #1;
        check("t1_aclr_grant_vld", 32'(bus.grant_vld), 0);
        check("t1_aclr_req_ack", 32'(bus.req_ack), 0);
        check("t1_aclr_fifo_wrreq", 32'(bus.fifo_wrreq), 0);
        check("t1_aclr_fifo_data", 32'(bus.fifo_data), 0);
        #1 i_aclr = 1'b0;
        run(14);
        check("t1_ack_c1", log_q[1], 2);
        check("t1_ack_c2", log_q[2], 2);
        check("t1_ack_c3", log_q[3], -1);
        check("t1_ack_c4", log_q[4], 1);
        check("t1_ack_c7", log_q[7], 2);

        // Single producer, 10 words: bursts 4/4/2 back to back.
        quiesce();
        load_prod(2, 10, 8'h30);
        drive_bus();
        run(13);
        check("t2_ack_c0", log_q[0], -1);
        check("t2_ack_c1", log_q[1], 2);
        check("t2_ack_c5", log_q[5], 2);
        check("t2_ack_c9", log_q[9], 2);
        check("t2_ack_c11", log_q[11], -1);
        check("t2_contig", count_owner(2, 1, 10), 10);
        check("t2_fifo_size", fifo_q.size(), 10);
        for (int k = 0; k < 10; k++) check("t2_fifo_order", 32'(fifo_q[k]), 32'h30 + k);

        // All requesting: 0,1,2,3,0 with 4 words each.
        quiesce();
        for (int i = 0; i < N; i++) load_prod(i, 8, W'(8'h40 + 16 * i));
        drive_bus();
        run(22);
        for (int k = 1; k <= 20; k++) check("t3_order", log_q[k], ((k - 1) / 4) % 4);
        max_run = 0;
        run_len = 0;
        for (int k = 1; k < log_q.size(); k++) begin
            run_len = (log_q[k] >= 0 && log_q[k] == log_q[k-1]) ? run_len + 1 : 1;
            if (run_len > max_run) max_run = run_len;
        end
        check("t3_max_run", max_run, 4);

        // Depth-4 FIFO pre-filled with 3 words; producer 1 sends 3.
        quiesce();
        fifo_depth = 4;
        fifo_q.push_back(8'hA0);
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hA2);
        load_prod(1, 3, 8'h50);
        drive_bus();
        run(5);
        pop_req = 1'b1;
        run(1);
        run(3);
        pop_req = 1'b1;
        run(1);
        run(4);
        check("t4_ack_c1", log_q[1], 1);
        check("t4_stall_c2", log_q[2], -1);
        check("t4_stall_c5", log_q[5], -1);
        check("t4_ack_c6", log_q[6], 1);
        check("t4_stall_c7", log_q[7], -1);
        check("t4_ack_c10", log_q[10], 1);
        check("t4_ack_total", count_owner(1, 0, log_q.size() - 1), 3);
        check("t4_fifo_size", fifo_q.size(), 4);
        check("t4_fifo_0", 32'(fifo_q[0]), 32'hA2);
        check("t4_fifo_1", 32'(fifo_q[1]), 32'h50);
        check("t4_fifo_2", 32'(fifo_q[2]), 32'h51);
        check("t4_fifo_3", 32'(fifo_q[3]), 32'h52);

        // Producer 0 drops after 2 words while 3 waits; 3 gets a fresh burst.
        quiesce();
        load_prod(0, 2, 8'h60);
        load_prod(3, 6, 8'h70);
        drive_bus();
        run(11);
        check("t5_ack_c1", log_q[1], 0);
        check("t5_ack_c2", log_q[2], 0);
        check("t5_gap_c3", log_q[3], -1);
        check("t5_ack_c4", log_q[4], 3);
        check("t5_burst", count_owner(3, 4, 7), 4);
        check("t5_ack_c8", log_q[8], 3);

        // sclr while producer 2 holds the grant and 1 is waiting.
        quiesce();
        load_prod(2, 8, 8'h80);
        drive_bus();
        run(2);
        load_prod(1, 4, 8'h90);
        bus.sclr = 1'b1;
        drive_bus();
        #2;
        check("t6_sclr_wrreq", 32'(bus.fifo_wrreq), 0);
        check("t6_sclr_ack", 32'(bus.req_ack), 0);
        run(1);
        bus.sclr = 1'b0;
        drive_bus();
        run(4);
        check("t6_ack_c1", log_q[1], 2);
        check("t6_ack_c2", log_q[2], -1);
        check("t6_ack_c3", log_q[3], -1);
        check("t6_ack_c4", log_q[4], 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
